// File: rtl/pipe_stage_buf.sv
// Two-entry valid/ready skid buffer between pipeline stages. It carries a data payload and a
// control vector, and supports flush plus masked kill of the incoming or the held head entry.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 16,
    parameter logic [CTRL_W-1:0] KILL_MASK = 16'h0001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_kill,
    input  logic              kill_head,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        count
);

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] h_data_q, h_data_d, s_data_q, s_data_d;
    logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d, s_ctrl_q, s_ctrl_d;

    logic              acc, pop;
    logic [CTRL_W-1:0] cin, h_ctrl_kept;

    // Handshake flags come from registered occupancy only, so in_ready never sees out_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = h_data_q;
    assign out_ctrl  = h_ctrl_q;
    assign count     = count_q;

    assign acc         = in_valid & in_ready;
    assign pop         = out_valid & out_ready;
    assign cin         = in_ctrl & ~(in_kill ? KILL_MASK : '0);
    assign h_ctrl_kept = h_ctrl_q & ~(kill_head ? KILL_MASK : '0);

    always_comb begin
        count_d  = count_q;
        h_data_d = h_data_q;
        h_ctrl_d = h_ctrl_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush) begin
            count_d  = 2'd0;
            h_ctrl_d = '0;
            s_ctrl_d = '0;
        end else begin
            unique case (count_q)
                2'd0: begin
                    if (acc) begin
                        h_data_d = in_data;
                        h_ctrl_d = cin;
                        count_d  = 2'd1;
                    end
                end
                2'd1: begin
                    if (acc && pop) begin
                        h_data_d = in_data;
                        h_ctrl_d = cin;
                    end else if (acc) begin
                        s_data_d = in_data;
                        s_ctrl_d = cin;
                        h_ctrl_d = h_ctrl_kept;
                        count_d  = 2'd2;
                    end else if (pop) begin
                        h_ctrl_d = h_ctrl_kept;
                        count_d  = 2'd0;
                    end else begin
                        h_ctrl_d = h_ctrl_kept;
                    end
                end
                2'd2: begin
                    if (pop) begin
                        h_data_d = s_data_q;
                        h_ctrl_d = s_ctrl_q;
                        count_d  = 2'd1;
                    end else begin
                        h_ctrl_d = h_ctrl_kept;
                    end
                end
                default: count_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 2'd0;
            h_data_q <= '0;
            h_ctrl_q <= '0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
        end else begin
            count_q  <= count_d;
            h_data_q <= h_data_d;
            h_ctrl_q <= h_ctrl_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: per-cycle stimulus table, scoreboard queue of accepted entries,
// and hand checks for kill, flush and asynchronous reset.
module tb_pipe_stage_buf;

    localparam logic [15:0] KMASK = 16'h0001;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, in_kill, kill_head, flush;
    logic         out_valid, out_ready;
    logic [127:0] in_data, out_data;
    logic [15:0]  in_ctrl, out_ctrl;
    logic [1:0]   count;

    pipe_stage_buf dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_kill   (in_kill),
        .kill_head (kill_head),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [127:0] d;
        logic [15:0]  c;
        logic         k;
        logic         ordy;
        logic         kh;
        logic         fl;
        logic [1:0]   cnt;
    } vec_t;

    typedef struct {
        logic [127:0] d;
        logic [15:0]  c;
    } ent_t;

    vec_t tbl[$];
    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [127:0] d, input logic [15:0] c,
                                input logic k, input logic ordy, input logic kh,
                                input logic fl, input logic [1:0] cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.k = k; v.ordy = ordy; v.kh = kh; v.fl = fl; v.cnt = cnt;
        return v;
    endfunction

    // Drives one record for one cycle; scoreboard updated from signals sampled at the negedge.
    task automatic step(input vec_t v, input int idx);
        ent_t e;
        logic acc, pop;
        in_valid  = v.iv;
        in_data   = v.d;
        in_ctrl   = v.c;
        in_kill   = v.k;
        out_ready = v.ordy;
        kill_head = v.kh;
        flush     = v.fl;
        @(negedge clk);
        acc = in_valid & in_ready;
        pop = out_valid & out_ready;
        if (pop) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output[%0d]: got %0h expected none", idx, out_data);
            end else begin
                e = sb.pop_front();
                check($sformatf("out_data[%0d]", idx), out_data, e.d);
                check($sformatf("out_ctrl[%0d]", idx), {112'd0, out_ctrl}, {112'd0, e.c});
            end
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (acc) begin
                e.d = in_data;
                e.c = in_kill ? (in_ctrl & ~KMASK) : in_ctrl;
                sb.push_back(e);
            end
            if (kill_head && out_valid && !pop && sb.size() > 0) sb[0].c = sb[0].c & ~KMASK;
        end
        @(posedge clk);
        #1;
        check($sformatf("count[%0d]", idx), {126'd0, count}, {126'd0, v.cnt});
    endtask

    task automatic idle_inputs();
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        in_kill   = 1'b0;
        out_ready = 1'b0;
        kill_head = 1'b0;
        flush     = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready", {127'd0, in_ready}, 128'd1);
        check("rst_count", {126'd0, count}, 128'd0);
        check("rst_out_data", out_data, 128'd0);
        check("rst_out_ctrl", {112'd0, out_ctrl}, 128'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        //                iv  data      ctrl      k  rdy kh fl cnt
        tbl.push_back(mk(1, 128'h1, 16'h0003, 0, 1, 0, 0, 2'd1)); // 0 stream
        tbl.push_back(mk(1, 128'h2, 16'h0003, 0, 1, 0, 0, 2'd1));
        tbl.push_back(mk(1, 128'h3, 16'h0003, 0, 1, 0, 0, 2'd1));
        tbl.push_back(mk(1, 128'h4, 16'h0003, 0, 1, 0, 0, 2'd1));
        tbl.push_back(mk(0, 128'h0, 16'h0000, 0, 1, 0, 0, 2'd0));
        tbl.push_back(mk(1, 128'hA, 16'h0003, 0, 0, 0, 0, 2'd1)); // 5 stall
        tbl.push_back(mk(1, 128'hB, 16'h0003, 0, 0, 0, 0, 2'd2));
        tbl.push_back(mk(1, 128'hC, 16'h0003, 0, 0, 0, 0, 2'd2));
        tbl.push_back(mk(1, 128'hC, 16'h0003, 0, 1, 0, 0, 2'd1));
        tbl.push_back(mk(1, 128'hC, 16'h0003, 0, 1, 0, 0, 2'd1));
        tbl.push_back(mk(0, 128'h0, 16'h0000, 0, 1, 0, 0, 2'd0));
        tbl.push_back(mk(1, 128'h55, 16'h00FF, 1, 0, 0, 0, 2'd1)); // 11 in_kill
        tbl.push_back(mk(1, 128'h66, 16'h0005, 0, 1, 0, 0, 2'd1)); // 12 kill_head
        tbl.push_back(mk(1, 128'h77, 16'h0007, 0, 0, 0, 0, 2'd2));
        tbl.push_back(mk(0, 128'h0, 16'h0000, 0, 0, 1, 0, 2'd2));
        tbl.push_back(mk(0, 128'h0, 16'h0000, 0, 1, 0, 0, 2'd1));
        tbl.push_back(mk(0, 128'h0, 16'h0000, 0, 1, 0, 0, 2'd0));
        tbl.push_back(mk(1, 128'h88, 16'h0001, 0, 0, 0, 0, 2'd1)); // 17 flush
        tbl.push_back(mk(1, 128'h99, 16'h0001, 0, 0, 0, 0, 2'd2));
        tbl.push_back(mk(1, 128'hAA, 16'h0001, 1, 0, 0, 1, 2'd0));
        tbl.push_back(mk(0, 128'h0, 16'h0000, 0, 1, 0, 0, 2'd0));
        tbl.push_back(mk(1, 128'hBB, 16'h0001, 0, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 128'hCC, 16'h0001, 0, 1, 0, 1, 2'd0));
        tbl.push_back(mk(0, 128'h0, 16'h0000, 0, 1, 0, 0, 2'd0));
        tbl.push_back(mk(1, 128'hD1, 16'h0003, 0, 0, 0, 0, 2'd1)); // 24 async reset
        tbl.push_back(mk(1, 128'hD2, 16'h0003, 0, 0, 0, 0, 2'd2));
        tbl.push_back(mk(1, 128'hE1, 16'h0003, 0, 1, 0, 0, 2'd1));
        tbl.push_back(mk(0, 128'h0, 16'h0000, 0, 1, 0, 0, 2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
            if (i == 6) check("full_in_ready", {127'd0, in_ready}, 128'd0);
            if (i == 11) begin
                check("kill_in_ctrl", {112'd0, out_ctrl}, 128'h00FE);
                check("kill_in_data", out_data, 128'h55);
            end
            if (i == 14) check("kill_head_ctrl", {112'd0, out_ctrl}, 128'h0004);
            if (i == 19) begin
                check("flush_out_valid", {127'd0, out_valid}, 128'd0);
                check("flush_out_ctrl", {112'd0, out_ctrl}, 128'd0);
            end
            if (i == 25) begin
                idle_inputs();
                #2;
                reset = 1'b1;
                #1;
                check("arst_out_valid", {127'd0, out_valid}, 128'd0);
                check("arst_count", {126'd0, count}, 128'd0);
                check("arst_out_data", out_data, 128'd0);
                check("arst_in_ready", {127'd0, in_ready}, 128'd1);
                sb.delete();
                #2;
                reset = 1'b0;
                @(posedge clk);
                #1;
            end
        end

        check("sb_drained", sb.size(), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised pipeline-stage buffer: a two-entry valid/ready skid buffer carrying an opaque data payload and a control-bit vector between two stages of the CPU pipeline. It generalises the fixed-field stage register that kills RegWrite on an exception response. Payload width, control width and the set of kill-able control bits are parameters, and the block adds back-pressure, full flush and in-place kill of the held head entry. It sits between any two adjacent stages, e.g. M→W; `in_ready` has no combinational path from `out_ready`.

## Interface
- `DATA_W`, 128: payload width (ALU result, PC, link address, HI/LO, ...).
- `CTRL_W`, 16: control-vector width (RegWrite, select fields, ...).
- `KILL_MASK`, 16'h0001: control bits forced to 0 by a kill. Width is `CTRL_W`; bit 0 is RegWrite by convention.
- `clk`  in  1  clock, all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream holds a valid entry.
- `in_ready`  out  1  buffer can accept this cycle.
- `in_data`  in  `DATA_W`  upstream payload.
- `in_ctrl`  in  `CTRL_W`  upstream control vector.
- `in_kill`  in  1  clear the `KILL_MASK` bits of the entry being accepted this cycle (exception response).
- `kill_head`  in  1  clear the `KILL_MASK` bits of the entry currently presented on the output.
- `flush`  in  1  discard all held entries and any same-cycle accept.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  downstream consumes the head this cycle.
- `out_data`  out  `DATA_W`  head payload.
- `out_ctrl`  out  `CTRL_W`  head control vector.
- `count`  out  2  occupancy, 0..2.

## Operation
- Storage: head register H (drives `out_*`) and skid register S. Each holds data + ctrl; valid is implied by `count`.
- `in_ready = (count != 2)`. `out_valid = (count != 0)`. Both are decoded from registered state only.
- `acc = in_valid & in_ready`; `pop = out_valid & out_ready`.
- Captured control: `cin = in_ctrl & ~(in_kill ? KILL_MASK : 0)`.
- State transitions (count), when `flush` = 0:
  - 0: `acc` → H←{`in_data`, `cin`}, count 1.
  - 1, `acc` & `pop`: H←in, stays 1.
  - 1, `acc` & !`pop`: S←in, count 2.
  - 1, !`acc` & `pop`: count 0.
  - 1, idle: no change.
  - 2, `pop`: H←S, count 1. No accept is possible in this state.
  - 2, !`pop`: hold.
- `kill_head` (`flush` = 0, count ≠ 0):
  - Clears the `KILL_MASK` bits of H when H is retained.
  - Clears them in the copy being popped: the current-cycle `out_ctrl` is unaffected, but the change is visible from the next edge if H stays.
  - Has no effect on S, on an entry moving S→H, or on a newly accepted entry.
  - Ignored when count = 0.
- `flush` has highest priority:
  - count←0.
  - H.ctrl and S.ctrl←0.
  - Same-cycle `acc` is discarded, although `in_ready` may be high that cycle.
  - `pop` in the same cycle still completes from the downstream view.
- When empty, `out_data` holds its last value. `out_ctrl` holds its last value, or 0 after flush/reset. Consumers must qualify with `out_valid`.
- Width rule: data and ctrl pass bit-exact; the only modification is the AND with `~KILL_MASK`.

## Timing
- Reset (async, immediate):
  - count = 0, `out_valid` = 0, `in_ready` = 1.
  - H and S data and ctrl = 0, so `out_data` = 0 and `out_ctrl` = 0.
- Latency: an entry accepted at edge N appears on `out_*` after edge N when the buffer was empty. Otherwise it appears behind the older entries.
- Throughput: one entry per cycle with `out_ready` held high. A single stall cycle is absorbed by S with no bubble.
- Handshake:
  - Upstream must hold `in_*` stable while `in_valid` & !`in_ready`.
  - The block holds `out_*` stable while `out_valid` & !`out_ready`, except for `kill_head`-cleared bits.
- Reset asserted mid-transfer drops all entries asynchronously. The first accept is possible on the first edge after deassertion.
- `in_kill` and `flush` together: flush wins, nothing is captured.

## Test plan
- Reset, then stream 4 entries (`in_data` = 1,2,3,4; `in_ctrl` = 16'h0003) with `out_ready` = 1 → outputs 1,2,3,4 on consecutive cycles, each one edge after accept; count stays ≤ 1.
- Hold `out_ready` = 0 while sending A = 0xA and B = 0xB → count = 2 and `in_ready` = 0; C is held upstream. Release `out_ready` → order A, B, C with no loss and no duplicate.
- Accept X with `in_kill` = 1 and `in_ctrl` = 16'h00FF → `out_ctrl` = 16'h00FE and `out_data` unchanged.
- Stall with head `out_ctrl` = 16'h0005 and pulse `kill_head` → next cycle `out_ctrl` = 16'h0004; S entry ctrl unchanged when later promoted.
- count = 2, assert `flush` together with `in_valid` = 1 → next cycle count = 0, `out_valid` = 0, `out_ctrl` = 0; the flushed input never appears.
- Assert `reset` asynchronously between edges with count = 2 → `out_valid` and `count` drop to 0 immediately without waiting for a clock edge. Afterwards `out_data` = 0 and `in_ready` = 1.
